// File: rtl/rename_regfile_pkg.sv
// Shared constants for the architectural register file and rename table.
// Defines the register count, data width and default ROB id width.
package rename_regfile_pkg;
   localparam int ROB_WIDTH_BIT_DEF = 5;
   localparam int REG_NUM = 32;
   localparam int REG_IDX_W = 5;
   localparam int XLEN = 32;
   localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/rename_regfile_lookup.sv
// Resolves a single source operand to a ready value or a pending ROB tag.
// Priority: x0, idle register, commit bypass, ROB forward, then pending.
module reg_operand_lookup
   import rename_regfile_pkg::*;
#(
   parameter int ROB_WIDTH_BIT = ROB_WIDTH_BIT_DEF
) (
   input  logic [REG_IDX_W-1:0]     idx,
   input  logic [XLEN-1:0]          reg_val,
   input  logic                     reg_busy,
   input  logic [ROB_WIDTH_BIT-1:0] reg_tag,
   input  logic [REG_IDX_W-1:0]     commit_rd,
   input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
   input  logic [XLEN-1:0]          commit_val,
   input  logic                     rob_ready,
   input  logic [XLEN-1:0]          rob_val,
   output logic                     dep,
   output logic [ROB_WIDTH_BIT-1:0] tag,
   output logic [XLEN-1:0]          val
);

   always_comb begin
      dep = 1'b0;
      tag = '0;
      val = '0;
      if (idx == REG_ZERO) begin
         val = '0;
      end else if (!reg_busy) begin
         val = reg_val;
      end else if (commit_rd == idx && commit_rob_id == reg_tag) begin
         val = commit_val;
      end else if (rob_ready) begin
         val = rob_val;
      end else begin
         dep = 1'b1;
         tag = reg_tag;
      end
   end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with rename-tag table between decoder and ROB.
// Commit, rename and mispredict flush update state; lookups are combinational.
module rename_regfile
   import rename_regfile_pkg::*;
#(
   parameter int ROB_WIDTH_BIT = ROB_WIDTH_BIT_DEF
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     rdy_in,
   input  logic                     clear_in,
   input  logic [REG_IDX_W-1:0]     commit_rd,
   input  logic [XLEN-1:0]          commit_val,
   input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
   input  logic [REG_IDX_W-1:0]     new_rd,
   input  logic [ROB_WIDTH_BIT-1:0] new_rob_id,
   input  logic [REG_IDX_W-1:0]     rs1_idx,
   input  logic [REG_IDX_W-1:0]     rs2_idx,
   output logic [ROB_WIDTH_BIT-1:0] rob_q1_id,
   output logic [ROB_WIDTH_BIT-1:0] rob_q2_id,
   input  logic                     rob_q1_ready,
   input  logic                     rob_q2_ready,
   input  logic [XLEN-1:0]          rob_q1_val,
   input  logic [XLEN-1:0]          rob_q2_val,
   output logic                     rs1_dep,
   output logic                     rs2_dep,
   output logic [ROB_WIDTH_BIT-1:0] rs1_tag,
   output logic [ROB_WIDTH_BIT-1:0] rs2_tag,
   output logic [XLEN-1:0]          rs1_val,
   output logic [XLEN-1:0]          rs2_val
);

   logic [XLEN-1:0]          value_q [REG_NUM];
   logic [ROB_WIDTH_BIT-1:0] tag_q   [REG_NUM];
   logic [REG_NUM-1:0]       busy_q;

   logic commit_en;
   logic commit_hit;
   logic rename_en;

   assign commit_en  = (commit_rd != REG_ZERO);
   assign commit_hit = commit_en
                    && (tag_q[commit_rd] == commit_rob_id)
                    && (new_rd != commit_rd);
   assign rename_en  = (new_rd != REG_ZERO);

   assign rob_q1_id = tag_q[rs1_idx];
   assign rob_q2_id = tag_q[rs2_idx];

   // Later assignments win: flush beats rename, rename beats commit clear.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         busy_q <= '0;
         for (int r = 0; r < REG_NUM; r++) begin
            value_q[r] <= '0;
            tag_q[r]   <= '0;
         end
      end else if (rdy_in) begin
         if (commit_en) begin
            value_q[commit_rd] <= commit_val;
         end
         if (commit_hit) begin
            busy_q[commit_rd] <= 1'b0;
         end
         if (clear_in) begin
            busy_q <= '0;
            for (int r = 0; r < REG_NUM; r++) begin
               tag_q[r] <= '0;
            end
         end else if (rename_en) begin
            busy_q[new_rd] <= 1'b1;
            tag_q[new_rd]  <= new_rob_id;
         end
      end
   end

   reg_operand_lookup #(
      .ROB_WIDTH_BIT(ROB_WIDTH_BIT)
   ) u_rs1 (
      .idx           (rs1_idx),
      .reg_val       (value_q[rs1_idx]),
      .reg_busy      (busy_q[rs1_idx]),
      .reg_tag       (tag_q[rs1_idx]),
      .commit_rd     (commit_rd),
      .commit_rob_id (commit_rob_id),
      .commit_val    (commit_val),
      .rob_ready     (rob_q1_ready),
      .rob_val       (rob_q1_val),
      .dep           (rs1_dep),
      .tag           (rs1_tag),
      .val           (rs1_val)
   );

   reg_operand_lookup #(
      .ROB_WIDTH_BIT(ROB_WIDTH_BIT)
   ) u_rs2 (
      .idx           (rs2_idx),
      .reg_val       (value_q[rs2_idx]),
      .reg_busy      (busy_q[rs2_idx]),
      .reg_tag       (tag_q[rs2_idx]),
      .commit_rd     (commit_rd),
      .commit_rob_id (commit_rob_id),
      .commit_val    (commit_val),
      .rob_ready     (rob_q2_ready),
      .rob_val       (rob_q2_val),
      .dep           (rs2_dep),
      .tag           (rs2_tag),
      .val           (rs2_val)
   );

endmodule

// File: doc/rename_regfile.md
# rename_regfile

Architectural register file with rename-tag table for the out-of-order core. It sits between the Decoder and the reorder buffer:
- **From the ROB:** takes in-order commit writes and new rename allocations.
- **To the Decoder:** resolves source operands into either a ready value or a pending ROB tag, querying the ROB for results that are finished but not yet committed.

A mispredict flush from the ROB discards all rename state in one cycle.

## Interface
- `ROB_WIDTH_BIT`, default `` `ROB_WIDTH_BIT `` (5): width of a ROB id.
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  asynchronous, active-low reset.
- `rdy_in`  in  1  pause when low: all state holds, combinational outputs stay valid.
- `clear_in`  in  1  ROB mispredict flush (ROB `clear_flag`).
- `commit_rd`  in  5  committing destination; 0 = no commit.
- `commit_val`  in  32  committed value.
- `commit_rob_id`  in  ROB_WIDTH_BIT  ROB entry committing.
- `new_rd`  in  5  destination being renamed this cycle; 0 = none.
- `new_rob_id`  in  ROB_WIDTH_BIT  ROB entry allocated to `new_rd`.
- `rs1_idx`, `rs2_idx`  in  5  source register indices from the Decoder.
- `rob_q1_id`, `rob_q2_id`  out  ROB_WIDTH_BIT  tag presented to the ROB for lookup.
- `rob_q1_ready`, `rob_q2_ready`  in  1  ROB reports that the entry's result is available.
- `rob_q1_val`, `rob_q2_val`  in  32  ROB result value.
- `rs1_dep`, `rs2_dep`  out  1  operand still pending.
- `rs1_tag`, `rs2_tag`  out  ROB_WIDTH_BIT  pending ROB id; 0 when `rsX_dep` = 0.
- `rs1_val`, `rs2_val`  out  32  operand value; 0 when `rsX_dep` = 1.

## Operation
State: `value[0:31]` (32 b), `busy[0:31]`, `tag[0:31]` (ROB_WIDTH_BIT).

Operand resolution is combinational and identical for rs1 and rs2. For index `i`, apply the first matching rule:
1. `i` = 0 → val 0, no dependency.
2. `busy[i]` = 0 → val `value[i]`, no dependency.
3. `commit_rd` = `i` and `commit_rob_id` = `tag[i]` → val `commit_val` (commit bypass).
4. `rob_qX_ready` → val `rob_qX_val`.
5. Otherwise → dependency, tag `tag[i]`.

`rob_qX_id` = `tag[rsX_idx]` at all times.

Lookups see pre-update state. The rename of the instruction being decoded in the same cycle is invisible to its own sources, so `add x1,x1,x2` reads the old x1 mapping.

Sequential update on posedge when `rdy_in` = 1:
- **Commit:** if `commit_rd` ≠ 0, `value[commit_rd] <= commit_val`. `busy` is cleared only if `tag[commit_rd]` = `commit_rob_id` and `new_rd` ≠ `commit_rd`.
- **Rename:** if `new_rd` ≠ 0, `busy[new_rd] <= 1` and `tag[new_rd] <= new_rob_id`. Rename overrides the commit's busy clear on the same register.
- **Flush:** if `clear_in`, all `busy` and `tag` are cleared. The same-cycle commit value write still lands; the same-cycle rename is discarded. Values are never cleared by flush.
- x0: never written, never busy.

Reset (`rst_in` low, asynchronous): all `value`, `busy` and `tag` go to 0. Outputs are therefore `rsX_dep` = 0, `rsX_val` = 0, `rsX_tag` = 0, `rob_qX_id` = 0.

## Timing
- Operand lookup has zero latency (combinational from `rsX_idx` and the ROB reply).
- Commit and rename take effect on the next edge; state is visible to lookups the following cycle.
- The ROB reply path (`rob_qX_*`) is combinational; there are no registers in the query loop.
- With `rdy_in` low, no state changes, including the flush, which is retried by the ROB.
- Reset assertion takes effect immediately without a clock. Release is synchronised externally.

## Structure
- `` `ROB_WIDTH_BIT `` and register-count constants live in shared `const.v`.
- One natural sub-module, `reg_operand_lookup`: it implements priority rules 1–5 for a single operand and is instantiated twice.
- Arrays and update logic stay in `rename_regfile`.

## Test plan
- **Reset:** pulse `rst_in` low mid-cycle → immediately `rs1_val` = 0 and `rs1_dep` = 0 for all indices.
- **Rename then commit:**
  - Rename x5→tag 3.
  - Next cycle query x5 with ROB not ready → `rs1_dep` = 1, `rs1_tag` = 3.
  - Commit x5 = 0x1234, id 3 → same-cycle query returns 0x1234 with no dependency.
  - Following cycle: `busy[5]` = 0, value 0x1234.
- **Stale commit:** rename x7→4, then x7→9. Commit x7 id 4 value 0xAA → `value[7]` = 0xAA, x7 still pending on tag 9.
- **Same-cycle commit and rename on x2:**
  - Commit x2 id 1 = 0x55 together with rename x2→6.
  - Next cycle x2 is pending on tag 6, and `value[2]` = 0x55.
- **ROB forward:** x3 pending on tag 8, ROB reports ready with 0xDEAD → `rs2_val` = 0xDEAD and `rs2_dep` = 0, with no state change.
- **Flush:**
  - x1 pending on tag 2 and x4 on tag 5, with `value[4]` = 0x77.
  - Assert `clear_in` together with rename x6→7 → next cycle all deps are 0, x4 reads 0x77, and x6 is not busy.
  - The same sequence with `rdy_in` = 0 → no change.
